// File: rtl/eth_phy_10g_pkg.sv
// Shared encodings and helpers for the 10G PHY SERDES-side test blocks.
package eth_phy_10g_pkg;

    // Injection modes
    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_SINGLE = 2'd1;
    localparam logic [1:0] MODE_BURST  = 2'd2;
    localparam logic [1:0] MODE_CONT   = 2'd3;

    // Corruption types
    localparam logic [1:0] ERR_HDR_ONES  = 2'd0;
    localparam logic [1:0] ERR_HDR_ZEROS = 2'd1;
    localparam logic [1:0] ERR_HDR_INV   = 2'd2;
    localparam logic [1:0] ERR_DATA_BIT  = 2'd3;

    // 64b/66b sync headers
    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    // Right-shifting Galois taps for x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } inj_state_e;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/eth_phy_10g_lfsr16.sv
// Seeded free-running 16-bit Galois LFSR; a zero seed is replaced by 1
// so the register can never lock up in the all-zero state.
module eth_phy_10g_lfsr16
    import eth_phy_10g_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state_o
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Next value of the shift register
    always_comb begin
        state_d = lfsr16_next(state_q);
    end

    // Advance once per cycle out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SEED_EFF;
        else        state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/eth_phy_10g_serdes_err_inj.sv
// SERDES-side fault injector: corrupts sync headers or single data bits
// under LFSR-driven probability, forced single shots, bursts or continuously,
// and keeps saturating counts of passed and corrupted blocks.
//
// state    | meaning
// ST_IDLE  | waiting for a trigger (or injecting per single/continuous mode)
// ST_BURST | injecting every block until the remaining count runs out
module eth_phy_10g_serdes_err_inj
    import eth_phy_10g_pkg::*;
#(
    parameter int          DATA_WIDTH = 64,
    parameter int          HDR_WIDTH  = 2,
    parameter int          PIPELINE   = 1,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [HDR_WIDTH-1:0]  in_hdr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [HDR_WIDTH-1:0]  out_hdr,
    output logic                  err_inj,
    input  logic [1:0]            cfg_mode,
    input  logic [1:0]            cfg_err_type,
    input  logic [15:0]           cfg_rate,
    input  logic [7:0]            cfg_burst_len,
    input  logic                  cfg_force,
    input  logic                  cfg_clear,
    output logic [CNT_WIDTH-1:0]  cnt_total,
    output logic [CNT_WIDTH-1:0]  cnt_err
);

    localparam int IDX_W = $clog2(DATA_WIDTH);

    logic [15:0]           lfsr;
    inj_state_e            state_q, state_d;
    logic [7:0]            remain_q, remain_d;
    logic                  trig;
    logic                  inject;
    logic [7:0]            burst_len_eff;
    logic [IDX_W-1:0]      flip_idx;
    logic [DATA_WIDTH-1:0] st0_data;
    logic [HDR_WIDTH-1:0]  st0_hdr;
    logic [CNT_WIDTH-1:0]  cnt_total_q, cnt_total_d;
    logic [CNT_WIDTH-1:0]  cnt_err_q, cnt_err_d;

    logic [DATA_WIDTH-1:0] data_q [PIPELINE];
    logic [HDR_WIDTH-1:0]  hdr_q  [PIPELINE];
    logic                  err_q  [PIPELINE];

    eth_phy_10g_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .state_o (lfsr)
    );

    assign trig          = cfg_force | (cfg_rate > lfsr);
    assign burst_len_eff = (cfg_burst_len == 8'd0) ? 8'd1 : cfg_burst_len;
    assign flip_idx      = lfsr[IDX_W-1:0];

    // Injection decision and burst bookkeeping
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        inject   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                unique case (cfg_mode)
                    MODE_OFF:    inject = 1'b0;
                    MODE_SINGLE: inject = trig;
                    MODE_BURST: begin
                        if (trig) begin
                            inject   = 1'b1;
                            remain_d = burst_len_eff - 8'd1;
                            if (burst_len_eff != 8'd1) state_d = ST_BURST;
                        end
                    end
                    default:     inject = 1'b1;
                endcase
            end
            default: begin
                if (cfg_mode != MODE_BURST) begin
                    // Leaving burst mode abandons the burst without a last hit
                    state_d  = ST_IDLE;
                    remain_d = 8'd0;
                end else begin
                    inject   = 1'b1;
                    remain_d = remain_q - 8'd1;
                    if (remain_q == 8'd1) state_d = ST_IDLE;
                end
            end
        endcase
    end

    // FSM state and remaining burst length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            remain_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    // Stage-0 corruption of the incoming block
    always_comb begin
        st0_data = in_data;
        st0_hdr  = in_hdr;
        if (inject) begin
            unique case (cfg_err_type)
                ERR_HDR_ONES:  st0_hdr  = {HDR_WIDTH{1'b1}};
                ERR_HDR_ZEROS: st0_hdr  = {HDR_WIDTH{1'b0}};
                ERR_HDR_INV:   st0_hdr  = ~in_hdr;
                default:       st0_data = in_data ^ ({{(DATA_WIDTH-1){1'b0}}, 1'b1} << flip_idx);
            endcase
        end
    end

    // Output pipeline: data, header and flag travel together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPELINE; i++) begin
                data_q[i] <= '0;
                hdr_q[i]  <= '0;
                err_q[i]  <= 1'b0;
            end
        end else begin
            data_q[0] <= st0_data;
            hdr_q[0]  <= st0_hdr;
            err_q[0]  <= inject;
            for (int i = 1; i < PIPELINE; i++) begin
                data_q[i] <= data_q[i-1];
                hdr_q[i]  <= hdr_q[i-1];
                err_q[i]  <= err_q[i-1];
            end
        end
    end

    assign out_data = data_q[PIPELINE-1];
    assign out_hdr  = hdr_q[PIPELINE-1];
    assign err_inj  = err_q[PIPELINE-1];

    // Saturating statistics; clear takes priority over counting
    always_comb begin
        cnt_total_d = cnt_total_q;
        cnt_err_d   = cnt_err_q;
        if (cfg_clear) begin
            cnt_total_d = '0;
            cnt_err_d   = '0;
        end else begin
            if (~&cnt_total_q)          cnt_total_d = cnt_total_q + 1'b1;
            if (inject && ~&cnt_err_q)  cnt_err_d   = cnt_err_q + 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_total_q <= '0;
            cnt_err_q   <= '0;
        end else begin
            cnt_total_q <= cnt_total_d;
            cnt_err_q   <= cnt_err_d;
        end
    end

    assign cnt_total = cnt_total_q;
    assign cnt_err   = cnt_err_q;

endmodule

// File: tb/tb_eth_phy_10g_serdes_err_inj.sv
// Directed bench for the SERDES fault injector: a PIPELINE=2 instance for
// function and latency, plus a 4-bit-counter instance for saturation.
module tb_eth_phy_10g_serdes_err_inj;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic [1:0]  in_hdr;
    logic [1:0]  cfg_mode, cfg_err_type;
    logic [15:0] cfg_rate;
    logic [7:0]  cfg_burst_len;
    logic        cfg_force, cfg_clear;

    logic [63:0] out_data, s_out_data;
    logic [1:0]  out_hdr, s_out_hdr;
    logic        err_inj, s_err_inj;
    logic [31:0] cnt_total, cnt_err;
    logic [3:0]  s_cnt_total, s_cnt_err;

    int errors = 0;
    int checks = 0;
    bit rec [10002];

    always #5 clk = ~clk;

    eth_phy_10g_serdes_err_inj #(.DATA_WIDTH(64), .PIPELINE(2), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_hdr(in_hdr),
        .out_data(out_data), .out_hdr(out_hdr), .err_inj(err_inj),
        .cfg_mode(cfg_mode), .cfg_err_type(cfg_err_type), .cfg_rate(cfg_rate),
        .cfg_burst_len(cfg_burst_len), .cfg_force(cfg_force), .cfg_clear(cfg_clear),
        .cnt_total(cnt_total), .cnt_err(cnt_err)
    );

    eth_phy_10g_serdes_err_inj #(.DATA_WIDTH(64), .PIPELINE(1), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_hdr(in_hdr),
        .out_data(s_out_data), .out_hdr(s_out_hdr), .err_inj(s_err_inj),
        .cfg_mode(cfg_mode), .cfg_err_type(cfg_err_type), .cfg_rate(cfg_rate),
        .cfg_burst_len(cfg_burst_len), .cfg_force(cfg_force), .cfg_clear(cfg_clear),
        .cnt_total(s_cnt_total), .cnt_err(s_cnt_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int i);
        logic [31:0] u;
        u = 32'(i);
        return {u * 32'h9E37_79B9, ~u};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset with an immediate check of the cleared state;
    // release lands on a falling edge so the next rising edge is the first counted.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_data", out_data, 64'h0);
        check("rst_hdr", {62'h0, out_hdr}, 64'h0);
        check("rst_err", {63'h0, err_inj}, 64'h0);
        check("rst_total", {32'h0, cnt_total}, 64'h0);
        check("rst_cnterr", {32'h0, cnt_err}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_burst(input logic [7:0] len, input int force2_at, input int abort_at,
                             output int hits, output int span);
        int first, last;
        hits = 0; first = -1; last = -1;
        cfg_mode = 2'd0; cfg_force = 1'b0; cfg_rate = 16'h0; cfg_err_type = 2'd0;
        cfg_burst_len = len; in_hdr = 2'b10; in_data = 64'h0;
        tick(); tick();
        for (int t = 0; t < 20; t++) begin
            cfg_force = (t == 0) || (t == force2_at);
            cfg_mode  = (abort_at >= 0 && t >= abort_at) ? 2'd0 : 2'd2;
            tick();
            if (err_inj) begin
                hits++;
                if (first < 0) first = t;
                last = t;
            end
        end
        cfg_force = 1'b0;
        cfg_mode  = 2'd0;
        span = (first < 0) ? 0 : last - first + 1;
    endtask

    task automatic run_rand(input int run, output int hits, output int diffs);
        hits = 0; diffs = 0;
        do_reset();
        cfg_mode = 2'd1; cfg_err_type = 2'd3; cfg_rate = 16'h0800;
        cfg_force = 1'b0; cfg_clear = 1'b0; in_hdr = 2'b10;
        for (int i = 0; i <= 10001; i++) begin
            in_data = pat(i);
            if (i == 10001) cfg_mode = 2'd0;
            tick();
            if (i >= 1) begin
                if (run == 0) rec[i] = err_inj;
                else if (rec[i] != err_inj) diffs++;
                if (err_inj) begin
                    hits++;
                    check("t4_onebit", 64'($countones(out_data ^ pat(i-1))), 64'd1);
                end else begin
                    check("t4_clean", out_data, pat(i-1));
                end
                check("t4_hdr", {62'h0, out_hdr}, 64'h2);
            end
        end
        check("t4_cnterr", {32'h0, cnt_err}, 64'(hits));
    endtask

    initial begin
        logic [1:0] ty [4];
        logic [1:0] hi [4];
        logic [1:0] hx [4];
        int hits, span, diffs, hits0;
        logic [31:0] e0;

        rst_n = 1'b0; in_data = '0; in_hdr = '0; cfg_mode = '0; cfg_err_type = '0;
        cfg_rate = '0; cfg_burst_len = '0; cfg_force = 1'b0; cfg_clear = 1'b0;

        // Pass-through with rate 0 in single mode
        do_reset();
        cfg_mode = 2'd1;
        for (int i = 0; i < 1000; i++) begin
            in_data = pat(i);
            in_hdr  = (i % 2 == 1) ? 2'b10 : 2'b01;
            tick();
            if (i >= 1) begin
                check("t1_data", out_data, pat(i-1));
                check("t1_hdr", {62'h0, out_hdr}, ((i-1) % 2 == 1) ? 64'h2 : 64'h1);
                check("t1_err", {63'h0, err_inj}, 64'h0);
            end
        end
        check("t1_total", {32'h0, cnt_total}, 64'd1000);
        check("t1_cnterr", {32'h0, cnt_err}, 64'd0);

        // Continuous header forcing, saturation and clear
        do_reset();
        cfg_mode = 2'd3; cfg_err_type = 2'd0; cfg_rate = 16'h0;
        in_data = 64'h0707070707070707; in_hdr = 2'b10;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i >= 1) begin
                check("t2_hdr", {62'h0, out_hdr}, 64'h3);
                check("t2_data", out_data, 64'h0707070707070707);
                check("t2_err", {63'h0, err_inj}, 64'h1);
            end
        end
        check("t2_total", {32'h0, cnt_total}, 64'd20);
        check("t2_cnterr", {32'h0, cnt_err}, 64'd20);
        check("sat_total", {60'h0, s_cnt_total}, 64'hF);
        check("sat_cnterr", {60'h0, s_cnt_err}, 64'hF);
        check("sat_hdr", {62'h0, s_out_hdr}, 64'h3);
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        check("clr_total", {32'h0, cnt_total}, 64'd0);
        check("clr_cnterr", {32'h0, cnt_err}, 64'd0);
        check("clr_sat_total", {60'h0, s_cnt_total}, 64'd0);
        check("clr_sat_cnterr", {60'h0, s_cnt_err}, 64'd0);

        // Header corruption table
        ty = '{2'd0, 2'd1, 2'd2, 2'd2};
        hi = '{2'b01, 2'b10, 2'b01, 2'b10};
        hx = '{2'b11, 2'b00, 2'b10, 2'b01};
        for (int k = 0; k < 4; k++) begin
            cfg_err_type = ty[k]; in_hdr = hi[k];
            tick(); tick();
            check("t2_type_hdr", {62'h0, out_hdr}, {62'h0, hx[k]});
            check("t2_type_data", out_data, 64'h0707070707070707);
        end
        cfg_mode = 2'd0;

        // Bursts: length 4 with a second force inside, length 0, abort
        e0 = cnt_err;
        run_burst(8'd4, 2, -1, hits, span);
        check("t3_len4_hits", 64'(hits), 64'd4);
        check("t3_len4_span", 64'(span), 64'd4);
        check("t3_len4_cnt", {32'h0, cnt_err - e0}, 64'd4);
        run_burst(8'd0, -1, -1, hits, span);
        check("t3_len0_hits", 64'(hits), 64'd1);
        run_burst(8'd10, -1, 3, hits, span);
        check("t3_abort_hits", 64'(hits), 64'd3);
        check("t3_abort_span", 64'(span), 64'd3);
        cfg_mode = 2'd2; cfg_burst_len = 8'd10;
        hits = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (err_inj) hits++;
        end
        check("t3_abort_idle", 64'(hits), 64'd0);
        cfg_mode = 2'd0;

        // Random single-bit hits, repeatable across reset
        run_rand(0, hits0, diffs);
        check("t4_ratio", {63'h0, (hits0 >= 220 && hits0 <= 410)}, 64'h1);
        run_rand(1, hits, diffs);
        check("t4_repeat_diffs", 64'(diffs), 64'd0);
        check("t4_repeat_hits", 64'(hits), 64'(hits0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eth_phy_10g_serdes_err_inj.md
Name: eth_phy_10g_serdes_err_inj

Overview:
Synthesizable SERDES-side fault injector. It sits between serdes_tx_data/serdes_tx_hdr and serdes_rx_data/serdes_rx_hdr in loopback benches and on FPGA bring-up builds. It corrupts sync headers or data bits under LFSR-controlled probability, single-shot, burst or continuous modes, so the RX block-lock, BER-monitor and watchdog logic can be exercised deterministically. It also keeps saturating counts of total and corrupted blocks.

Parameters:
DATA_WIDTH, 64, block payload width; power of 2, 16..64.
HDR_WIDTH, 2, sync header width; fixed at 2.
PIPELINE, 1, register stages from input to output; 1..4.
LFSR_SEED, 16'hACE1, LFSR reset value; a seed of 0 is replaced by 16'h0001.
CNT_WIDTH, 32, width of the statistics counters.

Ports:
clk  in  1  block clock; one block per cycle.
rst_n  in  1  reset; asynchronous, active-low.
in_data  in  DATA_WIDTH  block from the TX PCS (serdes_tx_data).
in_hdr  in  HDR_WIDTH  header from the TX PCS (serdes_tx_hdr).
out_data  out  DATA_WIDTH  block to the RX PCS (serdes_rx_data).
out_hdr  out  HDR_WIDTH  header to the RX PCS (serdes_rx_hdr).
err_inj  out  1  high when the current out_data/out_hdr was corrupted.
cfg_mode  in  2  0 off, 1 random single, 2 random burst, 3 continuous.
cfg_err_type  in  2  0 hdr:=2'b11, 1 hdr:=2'b00, 2 hdr^=2'b11, 3 flip one data bit.
cfg_rate  in  16  injection probability is cfg_rate/65536.
cfg_burst_len  in  8  burst length in blocks; 0 is treated as 1.
cfg_force  in  1  single-cycle trigger; ignores cfg_rate.
cfg_clear  in  1  synchronous clear of both counters.
cnt_total  out  CNT_WIDTH  blocks passed since reset or clear.
cnt_err  out  CNT_WIDTH  blocks corrupted since reset or clear.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All pipeline stages, out_data, out_hdr, err_inj, cnt_total and cnt_err go to 0.
  - FSM goes to IDLE and the burst counter to 0.
  - LFSR loads LFSR_SEED.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle out of reset, regardless of mode.
- Trigger in stage 0:
  - trig = cfg_force | (cfg_rate > lfsr).
  - cfg_rate=0 with cfg_force low never triggers.
- FSM states IDLE and BURST.
  - IDLE, mode 0: no injection.
  - IDLE, mode 1: inject iff trig.
  - IDLE, mode 2: trig injects and loads remaining = max(cfg_burst_len,1)-1. If remaining is nonzero, go to BURST.
  - IDLE, mode 3: inject every cycle; cfg_rate and cfg_force are ignored.
  - BURST: inject every cycle and decrement remaining. Return to IDLE when remaining reaches 0 after that cycle's injection.
  - BURST abort: if cfg_mode changes away from 2, return to IDLE with no injection in that cycle.
  - Triggers arriving during BURST are ignored and do not extend the burst.
- Corruption applied in stage 0 when inject:
  - Types 0, 1 and 2 modify the header only.
  - Type 3 inverts in_data[lfsr[log2(DATA_WIDTH)-1:0]]; the header is untouched.
- Latency:
  - Corrupted or clean data, header and err_inj move through PIPELINE register stages together.
  - They appear exactly PIPELINE cycles after the input cycle.
- Config: all cfg_* inputs are sampled every cycle. No shadowing.
- Counters, updated in stage 0 (they lead the outputs by PIPELINE-1 cycles):
  - cnt_total increments every cycle out of reset.
  - cnt_err increments on each injection.
  - Both saturate at all-ones.
  - cfg_clear forces both to 0 in that cycle; clear wins over increment.
- Reset mid-burst: burst is abandoned. After release the LFSR sequence restarts from the seed, so the injection pattern is repeatable.

Decomposition:
- Shared package eth_phy_10g_pkg holds:
  - mode encodings MODE_OFF/SINGLE/BURST/CONT;
  - error-type encodings;
  - sync header constants SYNC_DATA=2'b10, SYNC_CTRL=2'b01;
  - LFSR polynomial constant.
- One sub-module eth_phy_10g_lfsr16, a seeded free-running Galois LFSR reused by future PRBS/test blocks.
- FSM, corruption and pipeline stay in the top module.

Test Plan:
- Mode 1, cfg_rate=0, cfg_force=0, 1000 cycles of alternating 2'b01/2'b10 headers -> out equals in delayed PIPELINE cycles; err_inj never set; cnt_err=0, cnt_total=1000.
- Mode 3, type 0, PIPELINE=2, in_data=64'h0707070707070707 -> from cycle 2 on, out_hdr=2'b11 and out_data=64'h0707070707070707; cnt_err equals cnt_total.
- Mode 2, cfg_rate=0, cfg_burst_len=4, one cfg_force pulse -> exactly 4 consecutive err_inj cycles. A second force during the burst does not extend it; burst_len=0 gives a single-cycle burst.
- Mode 2 burst of 10 with cfg_mode switched to 0 after 3 injected blocks -> exactly 3 corrupted blocks, FSM in IDLE.
- CNT_WIDTH=4, mode 3 for 20 cycles -> both counters hold 4'hF; cfg_clear pulse -> both counters 0 the next cycle.
- Mode 1, cfg_rate=16'h0800, 10000 cycles, reset asserted, then rerun -> identical err_inj sequence both runs; ratio about 3.1%; type 3 flips exactly one data bit per hit.
